// File: rtl/spi_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_frame_pkg
// Description : Shared constants and types for the SPI vertex deframer:
//               frame opcodes, FSM state encodings, error-flag bit indices
//               and the vertex entry stored per FIFO slot.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_frame_pkg;

    // Coordinate / SPI word width carried in each FIFO entry.
    localparam int c_VTX_W = 16;

    // Accepted frame opcodes (header bits [15:8]).
    localparam logic [7:0] c_OP_POLYLINE = 8'h01;
    localparam logic [7:0] c_OP_POLYGON  = 8'h02;

    // Frame FSM state encoding.
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_HEADER = 3'd1;
    localparam logic [2:0] c_ST_X      = 3'd2;
    localparam logic [2:0] c_ST_Y      = 3'd3;
    localparam logic [2:0] c_ST_DRAIN  = 3'd4;

    // Bit positions inside err_flags = {overflow, abort, header}.
    localparam int c_ERR_HEADER   = 0;
    localparam int c_ERR_ABORT    = 1;
    localparam int c_ERR_OVERFLOW = 2;

    // One FIFO slot: a vertex plus the per-frame markers.
    typedef struct packed {
        logic [c_VTX_W-1:0] x;
        logic [c_VTX_W-1:0] y;
        logic [7:0]         op;
        logic               first;
        logic               last;
    } vertex_t;

    function automatic logic opcode_ok(input logic [7:0] op);
        return (op == c_OP_POLYLINE) || (op == c_OP_POLYGON);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vertex_commit_fifo.sv
`default_nettype none
// ============================================================================
// Module      : vertex_commit_fifo
// Description : Vertex FIFO with a tentative write pointer that can be
//               committed (published to the reader) or rewound (frame
//               discarded). Synchronous read into a show-ahead register.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               i_wr_en/i_wr_data - tentative write
//               i_commit          - publish all writes incl. this cycle's
//               i_rewind          - drop uncommitted writes
//               o_free            - DEPTH - (tentative wr - rd)
//               o_rd_*/i_rd_ready - valid/ready output stream
// Revision    : 1.0 - initial release
// ============================================================================
module vertex_commit_fifo
    import spi_frame_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_wr_en,
    input  vertex_t                i_wr_data,
    input  logic                   i_commit,
    input  logic                   i_rewind,
    output logic [$clog2(DEPTH):0] o_free,
    output vertex_t                o_rd_data,
    output logic                   o_rd_valid,
    input  logic                   i_rd_ready
);

    localparam int                 c_ADDR_W = $clog2(DEPTH);
    localparam int                 c_PTR_W  = c_ADDR_W + 1;
    localparam logic [c_PTR_W-1:0] c_DEPTH  = c_PTR_W'(DEPTH);

    vertex_t              r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr;
    logic [c_PTR_W-1:0]   r_commit;
    logic [c_PTR_W-1:0]   r_rd;
    vertex_t              r_out;
    logic                 r_out_valid;

    logic [c_PTR_W-1:0]   w_wr_next;
    logic [c_PTR_W-1:0]   w_rd_next;
    logic                 w_pop;
    logic                 w_avail;

    assign w_wr_next = i_wr_en ? (r_wr + c_PTR_W'(1)) : r_wr;
    assign w_pop     = r_out_valid && i_rd_ready;
    // The read pointer only moves on a consumer handshake, so the entry
    // sitting in the output register still counts as occupied.
    assign w_rd_next = r_rd + c_PTR_W'(w_pop);
    assign w_avail   = (r_commit != w_rd_next);

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[r_wr[c_ADDR_W-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr        <= '0;
            r_commit    <= '0;
            r_rd        <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (i_rewind) begin
                r_wr <= r_commit;
            end else begin
                r_wr <= w_wr_next;
            end
            if (i_commit) begin
                r_commit <= w_wr_next;
            end
            r_rd        <= w_rd_next;
            r_out_valid <= w_avail;
            // Slot at w_rd_next is committed whenever w_avail is set, so it
            // can never be the slot being written this cycle.
            r_out       <= w_avail ? r_mem[w_rd_next[c_ADDR_W-1:0]] : '0;
        end
    end

    assign o_free     = c_DEPTH - (r_wr - r_rd);
    assign o_rd_data  = r_out;
    assign o_rd_valid = r_out_valid;

endmodule
`default_nettype wire

// File: rtl/spi_vertex_deframer.sv
`default_nettype none
// ============================================================================
// Module      : spi_vertex_deframer
// Description : SPI mode-0 slave that receives framed vertex lists
//               (header {opcode, N} then N x/y word pairs), buffers them in
//               a commit/rewind FIFO and releases only complete frames as a
//               valid/ready vertex stream. MISO returns a status word
//               {err_flags, 5'b0, free_slots} during the header.
// Ports       : clock, reset              - system clock, sync reset
//               spi_sclk/mosi/cs/miso     - SPI slave pins (async inputs)
//               out_x/y/op/first/last     - vertex beat
//               out_valid/out_ready       - stream handshake
//               err_flags                 - sticky {overflow, abort, header}
// Revision    : 1.0 - initial release
// ============================================================================
module spi_vertex_deframer
    import spi_frame_pkg::*;
#(
    parameter int WORD_W      = c_VTX_W,
    parameter int MAX_VERTS   = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    input  logic              spi_cs,
    output logic              spi_miso,
    output logic [WORD_W-1:0] out_x,
    output logic [WORD_W-1:0] out_y,
    output logic [7:0]        out_op,
    output logic              out_first,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        err_flags
);

    localparam int                 c_PTR_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int                 c_BIT_W    = $clog2(WORD_W);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(WORD_W - 1);

    // ---------------- input synchronisers and edge detect ----------------
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic                   r_sclk_prev;
    logic                   r_cs_prev;
    logic                   w_sclk;
    logic                   w_mosi;
    logic                   w_cs;
    logic                   w_sclk_rise;
    logic                   w_sclk_fall;
    logic                   w_cs_fall;
    logic                   w_cs_rise;

    // Chains clear to 0 so a CS held low across reset is not seen as a new
    // frame start; its eventual rise lands in IDLE and is harmless.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_cs_sync   <= '0;
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs};
            r_sclk_prev <= w_sclk;
            r_cs_prev   <= w_cs;
        end
    end

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs        = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk && !r_sclk_prev;
    assign w_sclk_fall = !w_sclk && r_sclk_prev;
    assign w_cs_fall   = !w_cs && r_cs_prev;
    assign w_cs_rise   = w_cs && !r_cs_prev;

    // ---------------- frame state ----------------
    logic [2:0]          r_state;
    logic [c_BIT_W-1:0]  r_bit_cnt;
    logic [WORD_W-1:0]   r_shift;
    logic                r_word_done;
    logic [7:0]          r_op;
    logic [7:0]          r_n;
    logic [7:0]          r_vidx;
    logic [WORD_W-1:0]   r_x;
    logic [2:0]          r_err;
    logic [15:0]         r_miso_sr;

    logic [2:0]          w_state_nx;
    logic                w_in_frame;
    logic [7:0]          w_hdr_op;
    logic [7:0]          w_hdr_n;
    logic                w_hdr_ok;
    logic                w_last_vtx;
    logic                w_hdr_accept;
    logic                w_x_load;
    logic                w_wr_en;
    logic                w_commit;
    logic                w_rewind;
    logic [2:0]          w_err_set;
    logic                w_err_clr;
    logic [c_PTR_W-1:0]  w_free;
    vertex_t             w_wr_data;
    vertex_t             w_rd_data;
    logic                w_rd_valid;

    assign w_in_frame = (r_state == c_ST_HEADER) || (r_state == c_ST_X) || (r_state == c_ST_Y);
    assign w_hdr_op   = r_shift[15:8];
    assign w_hdr_n    = r_shift[7:0];
    assign w_hdr_ok   = opcode_ok(w_hdr_op) && (w_hdr_n != 8'd0) && (w_hdr_n <= 8'(MAX_VERTS));
    assign w_last_vtx = (r_vidx == (r_n - 8'd1));

    // Completed words are acted on one cycle after their last bit is
    // sampled (r_word_done). CS edges take priority over word handling.
    always_comb begin
        w_state_nx   = r_state;
        w_hdr_accept = 1'b0;
        w_x_load     = 1'b0;
        w_wr_en      = 1'b0;
        w_commit     = 1'b0;
        w_rewind     = 1'b0;
        w_err_set    = 3'b000;
        w_err_clr    = 1'b0;
        if (w_cs_rise) begin
            if (w_in_frame) begin
                w_rewind               = 1'b1;
                w_err_set[c_ERR_ABORT] = 1'b1;
            end
            w_state_nx = c_ST_IDLE;
        end else if (w_cs_fall) begin
            w_state_nx = c_ST_HEADER;
        end else if (r_word_done) begin
            case (r_state)
                c_ST_HEADER: begin
                    // Status word has just been fully shifted out.
                    w_err_clr = 1'b1;
                    if (!w_hdr_ok) begin
                        w_err_set[c_ERR_HEADER] = 1'b1;
                        w_state_nx              = c_ST_DRAIN;
                    end else if (w_hdr_n > 8'(w_free)) begin
                        w_err_set[c_ERR_OVERFLOW] = 1'b1;
                        w_state_nx                = c_ST_DRAIN;
                    end else begin
                        w_hdr_accept = 1'b1;
                        w_state_nx   = c_ST_X;
                    end
                end
                c_ST_X: begin
                    w_x_load   = 1'b1;
                    w_state_nx = c_ST_Y;
                end
                c_ST_Y: begin
                    w_wr_en = 1'b1;
                    if (w_last_vtx) begin
                        w_commit   = 1'b1;
                        w_state_nx = c_ST_DRAIN;
                    end else begin
                        w_state_nx = c_ST_X;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_wr_data.x     = r_x;
        w_wr_data.y     = r_shift;
        w_wr_data.op    = r_op;
        w_wr_data.first = (r_vidx == 8'd0);
        w_wr_data.last  = w_last_vtx;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_word_done <= 1'b0;
            r_op        <= '0;
            r_n         <= '0;
            r_vidx      <= '0;
            r_x         <= '0;
            r_err       <= '0;
            r_miso_sr   <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_word_done <= 1'b0;

            if (w_cs_fall) begin
                r_bit_cnt <= '0;
            end else if (w_sclk_rise && w_in_frame) begin
                r_shift <= {r_shift[WORD_W-2:0], w_mosi};
                if (r_bit_cnt == c_BIT_LAST) begin
                    r_bit_cnt   <= '0;
                    r_word_done <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
                end
            end

            if (w_hdr_accept) begin
                r_op   <= w_hdr_op;
                r_n    <= w_hdr_n;
                r_vidx <= '0;
            end
            if (w_x_load) begin
                r_x <= r_shift;
            end
            if (w_wr_en) begin
                r_vidx <= r_vidx + 8'd1;
            end

            if (w_cs_fall) begin
                r_miso_sr <= {r_err, 5'b00000, 8'(w_free)};
            end else if (w_sclk_fall && (r_state == c_ST_HEADER)) begin
                r_miso_sr <= {r_miso_sr[14:0], 1'b0};
            end

            // A flag raised in the clearing cycle survives the clear.
            r_err <= (w_err_clr ? 3'b000 : r_err) | w_err_set;
        end
    end

    vertex_commit_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clock),
        .rst        (reset),
        .i_wr_en    (w_wr_en),
        .i_wr_data  (w_wr_data),
        .i_commit   (w_commit),
        .i_rewind   (w_rewind),
        .o_free     (w_free),
        .o_rd_data  (w_rd_data),
        .o_rd_valid (w_rd_valid),
        .i_rd_ready (out_ready)
    );

    assign spi_miso  = (r_state == c_ST_HEADER) && r_miso_sr[15];
    assign out_x     = w_rd_data.x;
    assign out_y     = w_rd_data.y;
    assign out_op    = w_rd_data.op;
    assign out_first = w_rd_data.first;
    assign out_last  = w_rd_data.last;
    assign out_valid = w_rd_valid;
    assign err_flags = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_vertex_deframer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_spi_vertex_deframer
// Description : Directed scoreboard bench for spi_vertex_deframer. Stimulus
//               pushes expected beats into a queue; a monitor pops and
//               compares on every out_valid && out_ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_vertex_deframer;

    logic        clock     = 1'b0;
    logic        reset     = 1'b1;
    logic        spi_sclk  = 1'b0;
    logic        spi_mosi  = 1'b0;
    logic        spi_cs    = 1'b1;
    logic        out_ready = 1'b0;
    logic        spi_miso;
    logic [15:0] out_x;
    logic [15:0] out_y;
    logic [7:0]  out_op;
    logic        out_first;
    logic        out_last;
    logic        out_valid;
    logic [2:0]  err_flags;

    spi_vertex_deframer #(
        .WORD_W      (16),
        .MAX_VERTS   (8),
        .FIFO_DEPTH  (16),
        .SYNC_STAGES (2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .spi_cs    (spi_cs),
        .spi_miso  (spi_miso),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_op    (out_op),
        .out_first (out_first),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_flags (err_flags)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  op;
        logic        first;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       mon_got;
    beat_t       mon_exp;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          last_rise_cyc = 0;
    int          first_valid_cyc = 0;
    int          mark = 0;
    bit          valid_seen = 1'b0;
    logic [15:0] st;
    logic [15:0] dummy;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: every accepted beat must match the head of the scoreboard.
    always @(negedge clock) begin
        if (out_valid && !valid_seen) begin
            valid_seen      = 1'b1;
            first_valid_cyc = cyc;
        end
        if (!reset && out_valid && out_ready) begin
            mon_got = {out_x, out_y, out_op, out_first, out_last};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got %h, expected no beat", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL beat: got x=%0d y=%0d op=%h f=%b l=%b, expected x=%0d y=%0d op=%h f=%b l=%b",
                             mon_got.x, mon_got.y, mon_got.op, mon_got.first, mon_got.last,
                             mon_exp.x, mon_exp.y, mon_exp.op, mon_exp.first, mon_exp.last);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [15:0] x, input logic [15:0] y, input logic [7:0] op,
                        input logic first, input logic last);
        exp_q.push_back({x, y, op, first, last});
    endtask

    // Shift the first nbits of w MSB first; MISO is captured on each rise.
    task automatic spi_bits(input logic [15:0] w, input int nbits, output logic [15:0] miso_w);
        miso_w = '0;
        for (int i = 15; i > 15 - nbits; i--) begin
            spi_mosi = w[i];
            tick(4);
            spi_sclk      = 1'b1;
            last_rise_cyc = cyc;
            miso_w[i]     = spi_miso;
            tick(4);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic spi_word(input logic [15:0] w, output logic [15:0] miso_w);
        spi_bits(w, 16, miso_w);
    endtask

    task automatic vertex(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] d;
        spi_word(x, d);
        spi_word(y, d);
    endtask

    task automatic cs_start();
        spi_cs = 1'b0;
        tick(8);
    endtask

    task automatic cs_end();
        tick(4);
        spi_cs = 1'b1;
        tick(8);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            tick(1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d beats outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic push_square();
        push(16'd0,   16'd0,   8'h01, 1'b1, 1'b0);
        push(16'd0,   16'd100, 8'h01, 1'b0, 1'b0);
        push(16'd100, 16'd100, 8'h01, 1'b0, 1'b0);
        push(16'd100, 16'd0,   8'h01, 1'b0, 1'b1);
    endtask

    task automatic send_square(output logic [15:0] status);
        cs_start();
        spi_word(16'h0104, status);
        vertex(16'd0, 16'd0);
        vertex(16'd0, 16'd100);
        vertex(16'd100, 16'd100);
        vertex(16'd100, 16'd0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        tick(4);
        reset = 1'b0;
        tick(4);
        check("reset_valid", 32'(out_valid), 32'h0);
        check("reset_err",   32'(err_flags), 32'h0);
        check("reset_miso",  32'(spi_miso),  32'h0);
        check("reset_x",     32'(out_x),     32'h0);

        // Square frame; status word 0x0010 (no errors, 16 free).
        out_ready  = 1'b1;
        valid_seen = 1'b0;
        push_square();
        send_square(st);
        mark = last_rise_cyc;
        cs_end();
        wait_drain("square");
        check("status_initial", 32'(st), 32'h0010);
        // Two sync stages + edge detect put the sample edge 3 clocks after
        // the pin change; valid follows 2 clocks later.
        check("square_latency", 32'(first_valid_cyc), 32'(mark + 5));

        // Abort mid-way through the third x word.
        cs_start();
        spi_word(16'h0204, st);
        vertex(16'd1, 16'd2);
        vertex(16'd3, 16'd4);
        spi_bits(16'h0005, 7, dummy);
        cs_end();
        tick(20);
        check("abort_err",      32'(err_flags), 32'h2);
        check("abort_no_valid", 32'(out_valid), 32'h0);

        // Status readback after the abort, then flags clear.
        push(16'd5, 16'd7, 8'h01, 1'b1, 1'b1);
        cs_start();
        spi_word(16'h0101, st);
        check("status_after_abort", 32'(st), 32'h4010);
        vertex(16'd5, 16'd7);
        cs_end();
        wait_drain("readback");
        check("err_cleared", 32'(err_flags), 32'h0);

        // Bad headers: N above MAX_VERTS, then unknown opcode with N=0.
        cs_start();
        spi_word(16'h0109, st);
        vertex(16'd9, 16'd9);
        vertex(16'd8, 16'd8);
        cs_end();
        tick(20);
        check("bad_n_err",      32'(err_flags), 32'h1);
        check("bad_n_no_valid", 32'(out_valid), 32'h0);
        cs_start();
        spi_word(16'h0300, st);
        check("status_after_bad", 32'(st), 32'h2010);
        vertex(16'd1, 16'd1);
        cs_end();
        tick(20);
        check("bad_op_err",      32'(err_flags), 32'h1);
        check("bad_op_no_valid", 32'(out_valid), 32'h0);

        // Backpressure: two full frames fill the FIFO, a third is rejected.
        out_ready = 1'b0;
        for (int f = 0; f < 2; f++) begin
            cs_start();
            spi_word(16'h0108, st);
            for (int i = 0; i < 8; i++) begin
                push(16'(f * 16 + i), 16'(i * 3), 8'h01, (i == 0), (i == 7));
                vertex(16'(f * 16 + i), 16'(i * 3));
            end
            cs_end();
        end
        cs_start();
        spi_word(16'h0101, st);
        vertex(16'h0077, 16'h0077);
        cs_end();
        tick(20);
        check("overflow_err",   32'(err_flags), 32'h4);
        check("overflow_hold",  32'(out_valid), 32'h1);
        check("overflow_head",  32'(out_x),     32'h0);
        out_ready = 1'b1;
        wait_drain("overflow");
        tick(10);
        check("overflow_empty", 32'(out_valid), 32'h0);

        // Reset in the middle of vertex 2's y word.
        cs_start();
        spi_word(16'h0103, st);
        vertex(16'd10, 16'd20);
        spi_word(16'd30, dummy);
        spi_bits(16'd40, 5, dummy);
        reset = 1'b1;
        tick(3);
        check("midreset_valid", 32'(out_valid), 32'h0);
        check("midreset_err",   32'(err_flags), 32'h0);
        check("midreset_x",     32'(out_x),     32'h0);
        check("midreset_miso",  32'(spi_miso),  32'h0);
        reset = 1'b0;
        tick(2);
        spi_cs = 1'b1;
        tick(20);
        check("midreset_empty", 32'(out_valid), 32'h0);
        push_square();
        send_square(st);
        cs_end();
        wait_drain("post_reset_square");
        tick(10);
        check("final_idle", 32'(out_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_vertex_deframer.md
Name: spi_vertex_deframer

Overview:
SPI-slave front end for the drawing pipeline. It receives framed vertex lists from the host MCU over SPI mode 0, MSB first, and buffers whole frames in a commit/rewind FIFO. Only complete frames are released to the line rasteriser, as a valid/ready vertex stream. It replaces the fixed-length word shifter in Main and adds header-driven length, abort recovery, backpressure and a status readback on MISO.

Parameters:
WORD_W, 16, SPI word width in bits; also the coordinate width.
MAX_VERTS, 8, maximum vertex count N accepted in one header.
FIFO_DEPTH, 16, vertex slots; must be a power of two and at least MAX_VERTS.
SYNC_STAGES, 2, synchroniser flops on spi_sclk, spi_mosi and spi_cs.

Ports:
clock  in  1  system clock; at least 8x the SCLK rate.
reset  in  1  synchronous, active-high reset.
spi_sclk  in  1  SPI clock, asynchronous to clock.
spi_mosi  in  1  SPI data in.
spi_cs  in  1  chip select, active low.
spi_miso  out  1  status readback.
out_x  out  WORD_W  vertex x.
out_y  out  WORD_W  vertex y.
out_op  out  8  frame opcode.
out_first  out  1  first vertex of a frame.
out_last  out  1  last vertex of a frame.
out_valid  out  1  stream valid.
out_ready  in  1  stream ready.
err_flags  out  3  sticky flags {overflow, abort, header}.

Behaviour:
- Reset: all outputs 0, FIFO empty, FSM in IDLE, sticky flags cleared. Reset mid-frame discards the tentative frame.
- Synchronisers:
  - All three SPI inputs pass through SYNC_STAGES flops.
  - A rising edge of synced SCLK samples synced MOSI; a falling edge advances MISO.
  - A synced CS falling edge starts a frame: bit counter to 0, state HEADER.
- Frame format:
  - Header word: [15:8] opcode, [7:0] N.
  - Then N (x, y) word pairs.
- Header validation:
  - Valid only if opcode is 0x01 (polyline) or 0x02 (polygon) and 1 <= N <= MAX_VERTS.
  - Otherwise set err_header and go to DRAIN.
  - If N > free slots (FIFO_DEPTH minus tentative occupancy), set err_overflow and go to DRAIN; nothing is written.
- FSM: IDLE -> HEADER -> X -> Y, then Y -> X while vertices remain; after the Nth Y word -> DRAIN.
  - DRAIN ignores all bits until CS rises, then returns to IDLE.
  - CS rising in any state returns to IDLE.
- FIFO pointers:
  - Tentative write pointer: incremented one cycle after the last bit of each Y word is sampled.
  - Committed pointer: the reader sees only committed entries.
  - The commit happens in the same cycle as the Nth write, so out_valid rises 2 cycles after the final sampled bit.
- Abort:
  - CS rises while in HEADER/X/Y, including mid-word.
  - Tentative pointer rewinds to committed, err_abort is set, and no beat of that frame is ever presented.
- Stream:
  - Standard valid/ready; the output is stable while valid && !ready.
  - out_first/out_last/out_op are stored per entry. For N=1, first and last are both 1.
- Simultaneous read and write: allowed. The free-slot check uses the read pointer as it stands in the header-decision cycle.
- MISO status word:
  - Latched at CS fall: {err_flags[2:0], 5'b0, free_slots[7:0]}.
  - MSB is driven at CS fall and shifts on each synced SCLK fall during HEADER; 0 otherwise.
  - err_flags clear once the status word has been fully shifted out. A new error in that same cycle wins.
- Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally. Free slots = FIFO_DEPTH - (wr_tent - rd).

Decomposition:
- Package spi_frame_pkg:
  - opcode constants OP_POLYLINE=0x01, OP_POLYGON=0x02;
  - FSM state enum {IDLE, HEADER, X, Y, DRAIN};
  - vertex entry struct {x, y, op, first, last};
  - err-flag bit indices.
- Sub-module vertex_commit_fifo: the FIFO with commit/rewind, holding the entry struct; synchronous read, show-ahead output register.

Test Plan:
- Square frame: header 0x0104, then (0,0) (0,100) (100,100) (100,0), out_ready=1 -> 4 beats in order. first only on (0,0), last only on (100,0), out_op=0x01. out_valid is first high 2 cycles after the last sampled bit.
- Abort: header 0x0204, 2 vertices, CS raised mid-third x word -> no beats; err_flags=3'b010. The next status readback reports free_slots=16.
- Bad header: 0x0109 and, separately, 0x0300 -> err_flags=3'b001. No beats; the rest of the frame is ignored until CS rises.
- Backpressure/overflow: out_ready=0, send two frames of 0x0108 (16 entries), then a third 0x0101 -> third rejected, err_overflow set. Raise out_ready -> exactly 16 beats, first/last at 1 and 8 of each frame.
- Status readback: after an abort, clock out the next header -> MISO returns 0x4010 and err_flags read 0 afterward.
- Reset mid-frame: assert reset during the Y word of vertex 2 -> outputs 0 and FIFO empty. The following valid square frame is delivered intact.
